// File: rtl/movavg_param.sv
// movavg_param: pipelined sliding-window sum / floor average over TAPS samples.
// Ports: clk, reset, clear, din_valid, din -> dout_valid, dout, dout_primed.
module movavg_param #(
  parameter int WIDTH = 64,
  parameter int TAPS  = 4,
  parameter int AVG   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_primed
);

  localparam int L  = $clog2(TAPS);
  localparam int SW = WIDTH + L;
  localparam int N  = 2 * TAPS - 1;
  localparam logic [L-1:0] CMAX = L'(TAPS - 1);

  logic [WIDTH-1:0] hist [TAPS-1];
  logic [L-1:0]     cnt;
  // Heap-ordered adder tree: root at 0, leaves at TAPS-1..N-1.
  // Leaves form stage 0; each shallower level is one stage later.
  logic [SW-1:0]    node [N];
  logic [L:0]       vpipe;
  logic [L:0]       ppipe;
  logic             res_v;
  logic             res_p;
  logic [WIDTH-1:0] res_d;
  logic             primed_in;

  assign primed_in = din_valid && !clear && (cnt == CMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS - 1; i++) hist[i] <= '0;
      for (int n = 0; n < N; n++) node[n] <= '0;
      cnt         <= '0;
      vpipe       <= '0;
      ppipe       <= '0;
      res_v       <= 1'b0;
      res_p       <= 1'b0;
      res_d       <= '0;
      dout_valid  <= 1'b0;
      dout_primed <= 1'b0;
      dout        <= '0;
    end else begin
      // History shifts only on acceptance; clear wipes it.
      if (din_valid) begin
        hist[0] <= din;
        for (int i = 1; i < TAPS - 1; i++)
          hist[i] <= clear ? '0 : hist[i-1];
      end else if (clear) begin
        for (int i = 0; i < TAPS - 1; i++) hist[i] <= '0;
      end

      if (clear)
        cnt <= din_valid ? L'(1) : '0;
      else if (din_valid && cnt != CMAX)
        cnt <= cnt + L'(1);

      // Leaves: tap 0 is the new sample, the rest is history.
      node[TAPS-1] <= SW'(din);
      for (int i = 1; i < TAPS; i++)
        node[TAPS-1+i] <= clear ? '0 : SW'(hist[i-1]);

      for (int n = 0; n < TAPS - 1; n++)
        node[n] <= node[2*n+1] + node[2*n+2];

      vpipe <= {vpipe[L-1:0], din_valid};
      ppipe <= {ppipe[L-1:0], primed_in};

      res_v <= vpipe[L];
      res_p <= ppipe[L];
      res_d <= WIDTH'((AVG != 0) ? (node[0] >> L) : node[0]);

      dout_valid  <= res_v;
      dout_primed <= res_v & res_p;
      if (res_v)
        dout <= res_d;
    end
  end

endmodule
